// File: rtl/uart_rx_frame_checker.sv
// UART RX frame assembler: collects data/parity/stop bits from the sampler strobe,
// delivers the word with a one-cycle valid pulse and keeps saturating error counters.
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_start,
    input  logic                     i_bit_valid,
    input  logic                     i_sampled_bit,
    input  logic                     i_abort,
    input  logic                     i_cfg_par_en,
    input  logic [1:0]               i_cfg_par_mode,
    input  logic                     i_cfg_stop2,
    input  logic                     i_cnt_clr,
    output logic [DATA_WIDTH-1:0]    o_rx_data,
    output logic                     o_rx_valid,
    output logic                     o_par_err,
    output logic                     o_frm_err,
    output logic                     o_busy,
    output logic [ERR_CNT_WIDTH-1:0] o_par_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] o_frm_err_cnt
);

    // state  | meaning
    // IDLE   | waiting for frame_start
    // DATA   | shifting in data bits
    // PARITY | checking parity bit
    // STOP1  | checking first stop bit
    // STOP2  | checking second stop bit
    // DONE   | one cycle, deliver word and flags
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP1  = 3'd3;
    localparam logic [2:0] S_STOP2  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0]               LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [2:0]               r_state;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [3:0]               r_bit_cnt;
    logic                     r_par_acc;
    logic                     r_par_flag;
    logic                     r_frm_flag;
    logic                     r_par_en;
    logic [1:0]               r_par_mode;
    logic                     r_stop2;
    logic [DATA_WIDTH-1:0]    r_rx_data;
    logic                     r_rx_valid;
    logic                     r_par_err;
    logic                     r_frm_err;
    logic                     r_busy;
    logic [ERR_CNT_WIDTH-1:0] r_par_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_frm_cnt;

    logic [2:0] w_state_nxt;
    logic       w_par_exp;
    logic       w_start;
    logic       w_deliver;
    logic       w_bit;

    assign w_start   = (r_state == S_IDLE) && i_frame_start && !i_abort;
    assign w_deliver = (r_state == S_DONE) && !i_abort;
    assign w_bit     = i_bit_valid && !i_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_DATA;
            S_DATA:   if (i_bit_valid && (r_bit_cnt == LAST_BIT))
                          w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (i_bit_valid) w_state_nxt = S_STOP1;
            S_STOP1:  if (i_bit_valid) w_state_nxt = r_stop2 ? S_STOP2 : S_DONE;
            S_STOP2:  if (i_bit_valid) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // abort overrides every advance, including delivery
        if (i_abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_par_exp = 1'b0;
        case (r_par_mode)
            2'b00: w_par_exp = r_par_acc;
            2'b01: w_par_exp = ~r_par_acc;
            2'b10: w_par_exp = 1'b1;
            2'b11: w_par_exp = 1'b0;
            default: w_par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_acc  <= 1'b0;
            r_par_flag <= 1'b0;
            r_frm_flag <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_mode <= 2'b00;
            r_stop2    <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_par_cnt  <= '0;
            r_frm_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_rx_valid <= w_deliver;

            if (w_start) begin
                r_par_en   <= i_cfg_par_en;
                r_par_mode <= i_cfg_par_mode;
                r_stop2    <= i_cfg_stop2;
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_par_acc  <= 1'b0;
                r_par_flag <= 1'b0;
                r_frm_flag <= 1'b0;
            end

            if (w_bit) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {i_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                        r_par_acc <= r_par_acc ^ i_sampled_bit;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    S_PARITY: r_par_flag <= (i_sampled_bit != w_par_exp);
                    S_STOP1:  r_frm_flag <= ~i_sampled_bit;
                    S_STOP2:  r_frm_flag <= r_frm_flag | ~i_sampled_bit;
                    default:  ;
                endcase
            end

            if (w_deliver) begin
                r_rx_data <= r_shift;
                r_par_err <= r_par_flag;
                r_frm_err <= r_frm_flag;
            end

            // clear beats a same-cycle increment
            if (i_cnt_clr) begin
                r_par_cnt <= '0;
                r_frm_cnt <= '0;
            end else if (w_deliver) begin
                if (r_par_flag && (r_par_cnt != CNT_MAX)) r_par_cnt <= r_par_cnt + 1'b1;
                if (r_frm_flag && (r_frm_cnt != CNT_MAX)) r_frm_cnt <= r_frm_cnt + 1'b1;
            end
        end
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_par_err     = r_par_err;
    assign o_frm_err     = r_frm_err;
    assign o_busy        = r_busy;
    assign o_par_err_cnt = r_par_cnt;
    assign o_frm_err_cnt = r_frm_cnt;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker: frame-level model plus per-cycle compare,
// with an 8-bit-counter and a 2-bit-counter instance sharing the same stimulus.
module tb_uart_rx_frame_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       abort = 1'b0;
    logic       cfg_par_en = 1'b0;
    logic [1:0] cfg_par_mode = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       cnt_clr = 1'b0;

    logic [7:0] rx_data, rx_data2;
    logic       rx_valid, rx_valid2, par_err, par_err2, frm_err, frm_err2, busy, busy2;
    logic [7:0] pcnt8, fcnt8;
    logic [1:0] pcnt2, fcnt2;

    always #5 clk = ~clk;

    uart_rx_frame_checker #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start), .i_bit_valid(bit_valid),
        .i_sampled_bit(sampled_bit), .i_abort(abort), .i_cfg_par_en(cfg_par_en),
        .i_cfg_par_mode(cfg_par_mode), .i_cfg_stop2(cfg_stop2), .i_cnt_clr(cnt_clr),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_par_err(par_err), .o_frm_err(frm_err),
        .o_busy(busy), .o_par_err_cnt(pcnt8), .o_frm_err_cnt(fcnt8));

    uart_rx_frame_checker #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start), .i_bit_valid(bit_valid),
        .i_sampled_bit(sampled_bit), .i_abort(abort), .i_cfg_par_en(cfg_par_en),
        .i_cfg_par_mode(cfg_par_mode), .i_cfg_stop2(cfg_stop2), .i_cnt_clr(cnt_clr),
        .o_rx_data(rx_data2), .o_rx_valid(rx_valid2), .o_par_err(par_err2), .o_frm_err(frm_err2),
        .o_busy(busy2), .o_par_err_cnt(pcnt2), .o_frm_err_cnt(fcnt2));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic clr_s = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        clr_s <= cnt_clr;
    end

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } dlv_t;

    dlv_t q[$];
    logic [7:0] m_data = 8'h00;
    logic       m_pe = 1'b0;
    logic       m_fe = 1'b0;
    int m_pc8 = 0, m_fc8 = 0, m_pc2 = 0, m_fc2 = 0;
    int b_from = 1, b_to = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    always @(negedge clk) begin
        logic v;
        v = 1'b0;
        if (q.size() > 0 && q[0].at == cyc) begin
            v      = 1'b1;
            m_data = q[0].data;
            m_pe   = q[0].pe;
            m_fe   = q[0].fe;
            void'(q.pop_front());
        end
        if (clr_s) begin
            m_pc8 = 0; m_fc8 = 0; m_pc2 = 0; m_fc2 = 0;
        end else if (v) begin
            if (m_pe) begin m_pc8 = sat_inc(m_pc8, 255); m_pc2 = sat_inc(m_pc2, 3); end
            if (m_fe) begin m_fc8 = sat_inc(m_fc8, 255); m_fc2 = sat_inc(m_fc2, 3); end
        end
        check("rx_valid",  rx_valid,  v);
        check("rx_valid2", rx_valid2, v);
        check("rx_data",   rx_data,   m_data);
        check("rx_data2",  rx_data2,  m_data);
        check("par_err",   par_err,   m_pe);
        check("frm_err",   frm_err,   m_fe);
        check("busy",      busy,      (cyc >= b_from && cyc <= b_to));
        check("par_cnt8",  pcnt8,     m_pc8);
        check("frm_cnt8",  fcnt8,     m_fc8);
        check("par_cnt2",  pcnt2,     m_pc2);
        check("frm_cnt2",  fcnt2,     m_fc2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_valid   = 1'b1;
        sampled_bit = b;
        tick();
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_frame(input logic pen, input logic [1:0] mode, input logic s2,
                               input logic bv_at_start);
        cfg_par_en   = pen;
        cfg_par_mode = mode;
        cfg_stop2    = s2;
        frame_start  = 1'b1;
        bit_valid    = bv_at_start;
        sampled_bit  = 1'b1;
        tick();
        frame_start  = 1'b0;
        bit_valid    = 1'b0;
        sampled_bit  = 1'b0;
        b_from       = cyc;
        b_to         = 32'h3fff_ffff;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pen, input logic [1:0] mode,
                              input logic s2, input logic pbit, input logic st1, input logic st2,
                              input int gap, input logic clr_done, input logic twiddle,
                              input logic bv_at_start);
        int   ones;
        logic e, pe, fe, last;
        start_frame(pen, mode, s2, bv_at_start);
        if (twiddle) begin
            cfg_par_en   = ~pen;
            cfg_par_mode = ~mode;
            cfg_stop2    = ~s2;
        end
        for (int i = 0; i < 8; i++) send_bit(data[i], gap);
        if (pen) send_bit(pbit, gap);
        if (s2) begin
            send_bit(st1, gap);
            last = st2;
        end else begin
            last = st1;
        end
        bit_valid   = 1'b1;
        sampled_bit = last;
        tick();
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        b_to        = cyc;
        ones = $countones(data);
        case (mode)
            2'b00:   e = (ones % 2) == 1;
            2'b01:   e = (ones % 2) == 0;
            2'b10:   e = 1'b1;
            default: e = 1'b0;
        endcase
        pe = pen && (pbit != e);
        fe = !st1 || (s2 && !st2);
        q.push_back('{at: cyc + 1, data: data, pe: pe, fe: fe});
        cnt_clr = clr_done;
        tick();
        cnt_clr = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_data",  rx_data,  8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_busy",  busy,     1'b0);
        check("reset_pcnt",  pcnt8,    8'd0);

        // data, pen, mode, s2, pbit, st1, st2, gap, clr, twiddle, bv_at_start
        send_frame(8'hA5, 1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
        check("even_A5_data", rx_data, 8'hA5);
        check("even_A5_perr", par_err, 1'b0);
        check("even_A5_pcnt", pcnt8,   8'd0);

        send_frame(8'hA5, 1, 2'b01, 0, 0, 1, 1, 1, 0, 0, 0);
        check("odd_A5_perr", par_err, 1'b1);
        check("odd_A5_pcnt", pcnt8,   8'd1);

        send_frame(8'h3C, 1, 2'b01, 0, 1, 1, 1, 0, 0, 0, 1);
        check("odd_3C_data", rx_data, 8'h3C);
        check("odd_3C_perr", par_err, 1'b0);
        check("odd_3C_pcnt", pcnt8,   8'd1);

        send_frame(8'h12, 1, 2'b10, 0, 0, 1, 1, 0, 0, 0, 0);
        check("mark_perr", par_err, 1'b1);
        send_frame(8'h12, 1, 2'b11, 0, 0, 1, 1, 2, 0, 0, 0);
        check("space_perr", par_err, 1'b0);

        send_frame(8'h00, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
        check("nopar_data", rx_data, 8'h00);
        check("nopar_perr", par_err, 1'b0);

        send_frame(8'hA5, 1, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0);
        check("stop2_data", rx_data, 8'hA5);
        check("stop2_ferr", frm_err, 1'b1);
        check("stop2_fcnt", fcnt8,   8'd1);

        send_frame(8'h69, 1, 2'b00, 0, 0, 1, 1, 0, 0, 1, 0);
        check("twiddle_data", rx_data, 8'h69);
        check("twiddle_ferr", frm_err, 1'b0);

        // abort after the third data bit, with a bit strobe in the same cycle
        start_frame(1, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        abort       = 1'b1;
        bit_valid   = 1'b1;
        sampled_bit = 1'b1;
        tick();
        abort       = 1'b0;
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        b_to        = cyc - 1;
        tick();
        tick();
        check("abort_busy", busy,    1'b0);
        check("abort_data", rx_data, 8'h69);
        check("abort_pcnt", pcnt8,   8'd2);
        check("abort_fcnt", fcnt8,   8'd1);

        send_frame(8'h5A, 1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
        check("post_abort_data", rx_data, 8'h5A);

        // asynchronous reset in the middle of a frame
        start_frame(1, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_data",  rx_data,  8'h00);
        check("midrst_busy",  busy,     1'b0);
        check("midrst_pcnt",  pcnt8,    8'd0);
        check("midrst_fcnt",  fcnt8,    8'd0);
        check("midrst_perr",  par_err,  1'b0);
        q.delete();
        m_data = 8'h00; m_pe = 1'b0; m_fe = 1'b0;
        m_pc8 = 0; m_fc8 = 0; m_pc2 = 0; m_fc2 = 0;
        b_from = 1; b_to = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();

        for (int k = 0; k < 5; k++)
            send_frame(8'h01, 1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
        check("sat_pcnt2", pcnt2, 2'd3);
        check("sat_pcnt8", pcnt8, 8'd5);

        send_frame(8'h01, 1, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0);
        check("clr_pcnt2", pcnt2,   2'd0);
        check("clr_pcnt8", pcnt8,   8'd0);
        check("clr_perr",  par_err, 1'b1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
Parametrised successor to the UART RX single-bit parity checker. Assembles a complete UART frame from the per-bit sampler strobe and delivers the data word with a one-cycle valid pulse. Checks parity in four modes (even, odd, mark, space) and one or two stop bits, and keeps saturating error counters. Sits between the RX data sampler/start-check logic and the RX output register/FIFO.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9), received LSB first
ERR_CNT_WIDTH, 8, width of each saturating error counter (legal 1..16)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
frame_start  input  1  one-cycle pulse: start bit validated, first data bit follows
bit_valid  input  1  one-cycle strobe: sampled_bit holds the current bit's value
sampled_bit  input  1  majority-voted bit value from sampler
abort  input  1  one-cycle pulse: cancel the frame in progress (start glitch, line break)
cfg_par_en  input  1  1 = a parity bit follows the data bits
cfg_par_mode  input  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
cfg_stop2  input  1  1 = two stop bits checked
cnt_clr  input  1  synchronous clear of both error counters
rx_data  output  DATA_WIDTH  last delivered word
rx_valid  output  1  one-cycle pulse: rx_data, par_err and frm_err are valid
par_err  output  1  parity error of last delivered frame
frm_err  output  1  stop-bit error of last delivered frame
busy  output  1  high in any state other than IDLE
par_err_cnt  output  ERR_CNT_WIDTH  saturating count of delivered frames with par_err
frm_err_cnt  output  ERR_CNT_WIDTH  saturating count of delivered frames with frm_err

Behaviour:
- Reset (async, RST=1): state IDLE; rx_data=0, rx_valid=0, par_err=0, frm_err=0, busy=0, both counters 0, shift register, bit counter and running parity 0.
- Each state below advances only on a cycle with bit_valid=1. Cycles without bit_valid hold state.
- IDLE:
  - On frame_start, latch cfg_par_en, cfg_par_mode and cfg_stop2, then go to DATA. Clear the shift register, bit counter, running parity and internal error flags.
  - bit_valid in the same cycle as frame_start is ignored.
  - Config changes mid-frame have no effect.
- DATA:
  - Shift sampled_bit in at the MSB, shifting right, so the first bit ends up at bit 0.
  - Running parity ^= sampled_bit; bit counter increments.
  - On the DATA_WIDTH-th bit, go to PARITY if parity is enabled, otherwise STOP1.
- PARITY:
  - Expected bit: even = running parity; odd = ~running parity; mark = 1; space = 0.
  - Internal parity flag = (sampled_bit != expected). Go to STOP1.
- STOP1:
  - Internal frame flag set if sampled_bit=0.
  - If cfg_stop2 is latched, go to STOP2, otherwise DONE.
- STOP2: internal frame flag |= (sampled_bit=0). Go to DONE.
- DONE (exactly one cycle):
  - Registered outputs are visible in the cycle after DONE: rx_valid=1, rx_data = shift register, par_err/frm_err = internal flags.
  - Data is delivered even when errors are flagged.
  - Go to IDLE.
  - Latency: rx_valid rises 2 cycles after the bit_valid of the last stop bit.
- rx_data, par_err and frm_err hold until the next delivery.
- rx_valid is low in all other cycles.
- Counters:
  - Increment when a frame is delivered with the corresponding flag set.
  - Saturate at all-ones with no wrap.
  - cnt_clr wins over a same-cycle increment.
- abort: in any state except IDLE, the next state is IDLE.
  - No rx_valid and no counter change.
  - Outputs keep the values from the previous delivery.
  - abort in IDLE is ignored; abort wins over a same-cycle frame_start or bit_valid.
- frame_start outside IDLE is ignored.
- busy is registered: high from the cycle after frame_start until the state returns to IDLE.
- Reset mid-frame: immediate return to reset values; no partial delivery.

Test Plan:
- DATA_WIDTH=8, even parity, 1 stop. Send 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1 -> rx_valid one cycle, rx_data=0xA5, par_err=0, frm_err=0, both counters 0.
- Odd mode, 0xA5 with parity bit 0 -> par_err=1, par_err_cnt=1. Then odd mode, 0x3C with parity 1 -> par_err=0, par_err_cnt stays 1.
- Mark mode, parity 0, stop1=1 -> par_err=1. Space mode, parity 0 -> par_err=0. cfg_par_en=0, 0x00, stop 1 -> rx_data=0x00, no errors, no parity bit consumed.
- cfg_stop2=1, stop bits 1 then 0 -> frm_err=1, frm_err_cnt increments, rx_data=0xA5 still delivered. Toggling cfg_stop2 mid-frame -> no effect.
- abort after the 3rd data bit -> busy falls, no rx_valid, counters unchanged. Next frame 0x5A decodes correctly. RST=1 mid-frame -> all outputs 0 immediately.
- ERR_CNT_WIDTH=2, five parity-error frames -> par_err_cnt=3, held. cnt_clr in the same cycle as an error delivery -> counter=0.
